// File: rtl/nibble_add_pkg.sv
// Shared types and constants for the nibble-serial adder.
// Provides the FSM state enum, nibble width and a nibble-count helper.
package nibble_add_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  localparam int NIB_W = 4;

  function automatic int nnib(input int width);
    return width / NIB_W;
  endfunction

endpackage

// File: rtl/nibble_add_seq_add4.sv
// 4-bit ripple-carry adder slice built from full-adder cells.
// Ports: a[3:0], b[3:0], ci in; s[3:0], co out.
module fulladder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  logic p;

  assign p  = a ^ b;
  assign s  = p ^ ci;
  assign co = (a & b) | (ci & p);

endmodule

module add4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co
);

  logic [4:0] c;

  assign c[0] = ci;
  assign co   = c[4];

  for (genvar i = 0; i < 4; i++) begin : g_fa
    fulladder u_fa (
      .a  (a[i]),
      .b  (b[i]),
      .ci (c[i]),
      .s  (s[i]),
      .co (c[i+1])
    );
  end

endmodule

// File: rtl/nibble_add_seq.sv
// Multi-cycle WIDTH-bit add/sub using one 4-bit slice, LS nibble first.
// Ports: clk, rst_n, in_valid/in_ready/a/b/sub/cin, out_valid/out_ready/s/cout/ovf.
module nibble_add_seq
  import nibble_add_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf
);

  localparam int NNIB = nnib(WIDTH);
  localparam int IW   = (NNIB > 1) ? $clog2(NNIB) : 1;
  localparam logic [IW-1:0] LAST = IW'(NNIB - 1);

  state_t state, state_n;

  logic [IW-1:0]    idx;
  logic             carry;
  logic [WIDTH-1:0] areg;
  logic [WIDTH-1:0] breg;
  logic [WIDTH-1:0] sreg;
  logic             cout_r;
  logic             ovf_r;

  logic [3:0] a_nib;
  logic [3:0] b_nib;
  logic [3:0] sum;
  logic       co;
  logic       accept;
  logic       last;

  assign a_nib = areg[NIB_W*int'(idx) +: NIB_W];
  assign b_nib = breg[NIB_W*int'(idx) +: NIB_W];

  add4 u_add4 (
    .a  (a_nib),
    .b  (b_nib),
    .ci (carry),
    .s  (sum),
    .co (co)
  );

  assign accept    = (state == IDLE) && in_valid;
  assign last      = (idx == LAST);
  assign in_ready  = rst_n && (state == IDLE);
  assign out_valid = (state == DONE);
  assign s         = sreg;
  assign cout      = cout_r;
  assign ovf       = ovf_r;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: if (in_valid)  state_n = RUN;
      RUN:  if (last)      state_n = DONE;
      DONE: if (out_ready) state_n = IDLE;
      default:             state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx    <= '0;
      carry  <= 1'b0;
      areg   <= '0;
      breg   <= '0;
      sreg   <= '0;
      cout_r <= 1'b0;
      ovf_r  <= 1'b0;
    end else if (accept) begin
      idx   <= '0;
      areg  <= a;
      breg  <= sub ? ~b : b;
      carry <= sub ? 1'b1 : cin;
    end else if (state == RUN) begin
      sreg[NIB_W*int'(idx) +: NIB_W] <= sum;
      carry <= co;
      idx   <= idx + 1'b1;
      // Top slice sum bit is the result MSB; flags settle with it.
      if (last) begin
        cout_r <= co;
        ovf_r  <= (areg[WIDTH-1] == breg[WIDTH-1])
               && (sum[3] != areg[WIDTH-1]);
      end
    end
  end

endmodule

// File: tb/tb_nibble_add_seq.sv
// Self-checking bench for nibble_add_seq (WIDTH=16).
// Directed and random ops against an arithmetic reference model.
module tb_nibble_add_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        sub;
  logic        cin;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] s;
  logic        cout;
  logic        ovf;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  nibble_add_seq #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sub       (sub),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .s         (s),
    .cout      (cout),
    .ovf       (ovf)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Returns {ovf, cout, s} from plain integer arithmetic.
  function automatic logic [17:0] model(input logic [15:0] ma,
                                        input logic [15:0] mb,
                                        input logic ms,
                                        input logic mc);
    int sa;
    int sb;
    int r;
    int u;
    logic co;
    logic ov;
    sa = int'($signed(ma));
    sb = int'($signed(mb));
    if (ms) begin
      u  = int'(ma) - int'(mb);
      co = (ma >= mb);
      r  = sa - sb;
    end else begin
      u  = int'(ma) + int'(mb) + int'(mc);
      co = (u > 65535);
      r  = sa + sb + int'(mc);
    end
    ov = (r > 32767) || (r < -32768);
    return {ov, co, u[15:0]};
  endfunction

  task automatic do_op(input logic [15:0] ta,
                       input logic [15:0] tb,
                       input logic ts,
                       input logic tc,
                       input int hold);
    logic [17:0] e;
    e = model(ta, tb, ts, tc);
    @(negedge clk);
    chk("in_ready_idle", 32'(in_ready), 32'd1);
    a = ta; b = tb; sub = ts; cin = tc;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    a = 16'($urandom); b = 16'($urandom);
    sub = 1'($urandom); cin = 1'($urandom);
    chk("in_ready_run", 32'(in_ready), 32'd0);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      chk($sformatf("out_valid_e%0d", k), 32'(out_valid),
          32'(k == 4));
    end
    chk("s", 32'(s), 32'(e[15:0]));
    chk("cout", 32'(cout), 32'(e[16]));
    chk("ovf", 32'(ovf), 32'(e[17]));
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'b1;
      @(negedge clk);
      chk("hold_valid", 32'(out_valid), 32'd1);
      chk("hold_s", 32'(s), 32'(e[15:0]));
      chk("hold_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("idle_valid", 32'(out_valid), 32'd0);
    chk("idle_in_ready", 32'(in_ready), 32'd1);
    chk("idle_s_held", 32'(s), 32'(e[15:0]));
    chk("idle_cout_held", 32'(cout), 32'(e[16]));
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    a = '0; b = '0; sub = 1'b0; cin = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_s", 32'(s), 32'd0);
    chk("rst_cout", 32'(cout), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel_in_ready", 32'(in_ready), 32'd1);

    do_op(16'h1234, 16'h4321, 1'b0, 1'b0, 0);
    chk("add_5555", 32'(s), 32'h5555);
    do_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 0);
    chk("ripple_s", 32'(s), 32'h0000);
    chk("ripple_cout", 32'(cout), 32'd1);
    do_op(16'h7FFF, 16'h0000, 1'b0, 1'b1, 0);
    chk("ovf_add", 32'(ovf), 32'd1);
    do_op(16'h0005, 16'h0007, 1'b1, 1'b1, 0);
    chk("sub_s", 32'(s), 32'hFFFE);
    chk("sub_borrow", 32'(cout), 32'd0);
    do_op(16'h8000, 16'h0001, 1'b1, 1'b0, 0);
    chk("sub_ovf", 32'(ovf), 32'd1);

    do_op(16'hA5A5, 16'h0F0F, 1'b0, 1'b1, 3);

    // Reset after nibble 1 has been written.
    @(negedge clk);
    a = 16'h1111; b = 16'h2222; sub = 1'b0; cin = 1'b0;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_s", 32'(s), 32'd0);
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("mid_rel_in_ready", 32'(in_ready), 32'd1);
    chk("mid_rel_valid", 32'(out_valid), 32'd0);
    do_op(16'h0F00, 16'h00F0, 1'b0, 1'b0, 0);

    for (int i = 0; i < 25; i++) begin
      do_op(16'($urandom), 16'($urandom), 1'($urandom),
            1'($urandom), int'($urandom_range(0, 2)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
